v_issue_ctrl: RTL and testbench
===============================

# v_issue_ctrl

In-order issue controller for the vector coprocessor. It sits between the base processor's instruction port and the vector datapath (decoder, lanes, reduction, slide, load and store units, writeback). It buffers incoming vector instructions and holds the head instruction stable on the decoder while the selected functional unit executes. It issues one start pulse per instruction, waits for that unit's done, and then releases a single writeback commit pulse. It also provides back-pressure, a completion timeout and sticky error flags.

## Interface
Parameters:
- `QDEPTH`, default 2: instruction queue depth; power of two, ≥ 2.
- `TIMEOUT`, default 64: maximum number of cycles spent in ISSUE + WAIT before an abort; must be ≥ 2.

Ports (clock and reset first):
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `instr_valid`  in  1  the base processor offers `instr_in`.
- `instr_in`  in  32  vector instruction word.
- `instr_ready`  out  1  queue not full; a push occurs when `instr_valid && instr_ready`.
- `dec_instr`  out  32  head-of-queue instruction, driven to `v_decoder`; 0 when the queue is empty.
- `dec_unit`  in  3  unit class decoded from `dec_instr`, same cycle:
  - 0 illegal, 1 VALU, 2 VMUL, 3 VRED, 4 VSLDU, 5 VLOAD, 6 VSTORE, 7 VCONFIG.
- `dec_wr_dest`  in  1  the head instruction writes a vector or scalar destination.
- `unit_start`  out  6  one-hot start; bit k-1 corresponds to unit class k (1..6).
- `unit_done`  in  6  per-unit done; bit k-1 corresponds to unit class k.
- `vconfig_wr_en`  out  1  one-cycle CSR write strobe.
- `wb_en`  out  1  one-cycle commit strobe; gates the writeback register/element write enables.
- `busy`  out  1  `state != IDLE || count != 0`.
- `err_illegal`  out  1  sticky.
- `err_timeout`  out  1  sticky.
- `err_clr`  in  1  synchronous clear of both sticky error flags.

## Operation
- Queue: circular buffer with read and write pointers and `count` (0..QDEPTH).
  - Push when `instr_valid && instr_ready`.
  - Pop only as defined by the FSM below.
  - Push and pop in the same cycle leave `count` unchanged.
  - Pointers wrap modulo QDEPTH.
- FSM states: IDLE, ISSUE, WAIT, COMMIT.
- IDLE with `count == 0`: remain in IDLE.
- IDLE with `count > 0`, decided on `dec_unit`:
  - 0: set `err_illegal`, pop, remain in IDLE.
  - 7: `vconfig_wr_en = 1` in this cycle, pop, remain in IDLE.
  - 1–6: latch `cur_unit`, go to ISSUE.
- ISSUE: `unit_start[cur_unit-1] = 1` for exactly one cycle. Go to COMMIT if `unit_done[cur_unit-1]` is high; otherwise go to WAIT.
- WAIT: remain in WAIT until `unit_done[cur_unit-1]`, then go to COMMIT.
  - Done bits of other units are ignored.
- COMMIT: `wb_en = dec_wr_dest` (a store gives 0). Pop and return to IDLE.
- The head instruction stays on `dec_instr` from IDLE through COMMIT, so decoder outputs are stable for the whole execution.
- Timeout: a cycle counter clears on entry to ISSUE and increments in ISSUE and WAIT.
  - When it reaches TIMEOUT without a done: set `err_timeout`, pop, return to IDLE, with no `wb_en`.
- Error flags: `err_clr` clears them. If a new error event and `err_clr` occur in the same cycle, the set wins.
- Simultaneous push while full cannot occur, because `instr_ready` is low. A push during the COMMIT pop is accepted.

## Timing
- Reset values:
  - `instr_ready = 1`, `dec_instr = 0`.
  - `unit_start = 0`, `vconfig_wr_en = 0`, `wb_en = 0`.
  - `busy = 0`, `err_illegal = 0`, `err_timeout = 0`.
  - State IDLE, `count = 0`, pointers = 0.
- Asserting `rst` mid-operation flushes the queue and drops the in-flight instruction. No start, commit or CSR strobes are emitted after reset asserts.
- Output registration:
  - `unit_start` and `wb_en` are decoded from the registered state.
  - `vconfig_wr_en` is combinational from (IDLE, `count > 0`, `dec_unit == 7`).
- Latency for an instruction pushed at cycle t into an empty, idle queue:
  - IDLE decision at t+1.
  - Start at t+2.
  - Done at the earliest at t+2.
  - `wb_en` at done+1.
  - Next issue no earlier than 2 cycles after COMMIT.
- VCONFIG throughput: one per cycle.

## Structure
- `v_pkg` adds:
  - `typedef enum logic [2:0] v_unit_e` (the unit classes above).
  - `typedef enum logic [1:0] v_issue_state_e`.
  - Constants `V_NUM_UNITS = 6` and `V_ISSUE_TIMEOUT_DEF = 64`.
- Sub-module `v_instr_fifo` (parameterised width and depth, with `full`, `empty`, `count` outputs). The FSM and timeout counter live in `v_issue_ctrl`.

## Test plan
- ALU instruction `0x02208057` with `dec_unit=1`, `dec_wr_dest=1`, pushed at cycle 0; done pulsed at cycle 5 → `unit_start=6'b000001` at cycle 2 only, `wb_en=1` at cycle 6 only, `busy` low at cycle 7.
- Three pushes on back-to-back cycles with QDEPTH=2 and a VLOAD that takes 10 cycles → `instr_ready=0` once `count=2`; the third instruction is accepted after the first COMMIT. Issue order matches push order.
- VSTORE (`dec_unit=6`, `dec_wr_dest=0`) with done in the same cycle as start → ISSUE goes directly to COMMIT, `wb_en` stays 0, and the entry is popped.
- Four consecutive VCONFIG instructions → `vconfig_wr_en` high for 4 consecutive cycles and no `unit_start`.
- VMUL with no done, TIMEOUT=8 → `err_timeout` rises 8 cycles after start, with no `wb_en`. The next queued instruction then issues. `err_clr` clears the flag.
- `dec_unit=0` gives `err_illegal=1` and a pop. `rst` asserted during WAIT gives all outputs at reset values in the same cycle; a done arriving after reset deasserts produces no `wb_en`.

Source files
------------

// File: rtl/v_pkg.sv
// Shared types and constants for the vector coprocessor issue path.
package v_pkg;

  localparam int V_NUM_UNITS         = 6;
  localparam int V_ISSUE_TIMEOUT_DEF = 64;

  typedef enum logic [2:0] {
    U_ILLEGAL = 3'd0,
    U_VALU    = 3'd1,
    U_VMUL    = 3'd2,
    U_VRED    = 3'd3,
    U_VSLDU   = 3'd4,
    U_VLOAD   = 3'd5,
    U_VSTORE  = 3'd6,
    U_VCONFIG = 3'd7
  } v_unit_e;

  // IDLE: decide on head | ISSUE: start pulse | WAIT: await done | COMMIT: wb strobe + pop
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_COMMIT = 2'd3
  } v_issue_state_e;

  function automatic logic [V_NUM_UNITS-1:0] unit_onehot(v_unit_e u);
    logic [V_NUM_UNITS-1:0] oh;
    for (int k = 0; k < V_NUM_UNITS; k++) oh[k] = (3'(u) == 3'(k + 1));
    return oh;
  endfunction

endpackage

// File: rtl/v_issue_ctrl_if.sv
// Instruction port, decoder feedback and functional-unit handshake of the issue controller.
interface v_issue_ctrl_if;
  import v_pkg::*;

  logic                   instr_valid;
  logic [31:0]            instr_in;
  logic                   instr_ready;
  logic [31:0]            dec_instr;
  logic [2:0]             dec_unit;
  logic                   dec_wr_dest;
  logic [V_NUM_UNITS-1:0] unit_start;
  logic [V_NUM_UNITS-1:0] unit_done;
  logic                   vconfig_wr_en;
  logic                   wb_en;
  logic                   busy;
  logic                   err_illegal;
  logic                   err_timeout;
  logic                   err_clr;

  modport slave (
    input  instr_valid, instr_in, dec_unit, dec_wr_dest, unit_done, err_clr,
    output instr_ready, dec_instr, unit_start, vconfig_wr_en, wb_en, busy,
           err_illegal, err_timeout
  );

  modport master (
    output instr_valid, instr_in, dec_unit, dec_wr_dest, unit_done, err_clr,
    input  instr_ready, dec_instr, unit_start, vconfig_wr_en, wb_en, busy,
           err_illegal, err_timeout
  );

endinterface

// File: rtl/v_instr_fifo.sv
// Circular instruction buffer; push/pop are ignored when full/empty respectively.
module v_instr_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/v_issue_ctrl.sv
// In-order issue controller: holds the queue head on the decoder, starts one unit,
// waits for its done (bounded by TIMEOUT) and emits a single writeback commit strobe.
module v_issue_ctrl
  import v_pkg::*;
#(
  parameter int QDEPTH  = 2,
  parameter int TIMEOUT = V_ISSUE_TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            rst,
  v_issue_ctrl_if.slave   bus
);
  localparam int CW = $clog2(TIMEOUT + 1);

  v_issue_state_e         state_q, state_d;
  v_unit_e                cur_unit_q, cur_unit_d;
  logic [CW-1:0]          tmo_q, tmo_d;
  logic                   err_ill_q, err_ill_d;
  logic                   err_tmo_q, err_tmo_d;

  logic                   push, pop, full, empty, vcfg, done;
  logic [31:0]            head;
  logic [$clog2(QDEPTH):0] count;
  v_unit_e                unit;

  v_instr_fifo #(.WIDTH(32), .DEPTH(QDEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (bus.instr_in),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign push = bus.instr_valid && !full;
  assign unit = v_unit_e'(bus.dec_unit);
  assign done = |(bus.unit_done & unit_onehot(cur_unit_q));

  always_comb begin
    state_d    = state_q;
    cur_unit_d = cur_unit_q;
    tmo_d      = tmo_q;
    err_ill_d  = err_ill_q;
    err_tmo_d  = err_tmo_q;
    pop        = 1'b0;
    vcfg       = 1'b0;
    // clear first so a same-cycle error event overrides it
    if (bus.err_clr) begin
      err_ill_d = 1'b0;
      err_tmo_d = 1'b0;
    end
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          case (unit)
            U_ILLEGAL: begin
              err_ill_d = 1'b1;
              pop       = 1'b1;
            end
            U_VCONFIG: begin
              vcfg = 1'b1;
              pop  = 1'b1;
            end
            default: begin
              cur_unit_d = unit;
              tmo_d      = '0;
              state_d    = S_ISSUE;
            end
          endcase
        end
      end
      S_ISSUE, S_WAIT: begin
        if (done) begin
          state_d = S_COMMIT;
        end else if (tmo_q == CW'(TIMEOUT - 1)) begin
          err_tmo_d = 1'b1;
          pop       = 1'b1;
          state_d   = S_IDLE;
        end else begin
          tmo_d   = tmo_q + 1'b1;
          state_d = S_WAIT;
        end
      end
      S_COMMIT: begin
        pop     = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cur_unit_q <= U_ILLEGAL;
      tmo_q      <= '0;
      err_ill_q  <= 1'b0;
      err_tmo_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_unit_q <= cur_unit_d;
      tmo_q      <= tmo_d;
      err_ill_q  <= err_ill_d;
      err_tmo_q  <= err_tmo_d;
    end
  end

  assign bus.instr_ready   = !full;
  assign bus.dec_instr     = empty ? 32'h0 : head;
  assign bus.unit_start    = (state_q == S_ISSUE) ? unit_onehot(cur_unit_q) : '0;
  assign bus.wb_en         = (state_q == S_COMMIT) && bus.dec_wr_dest;
  assign bus.vconfig_wr_en = vcfg;
  assign bus.busy          = (state_q != S_IDLE) || (count != '0);
  assign bus.err_illegal   = err_ill_q;
  assign bus.err_timeout   = err_tmo_q;

endmodule

// File: tb/tb_v_issue_ctrl.sv
// Directed bench for v_issue_ctrl; a small decoder model feeds dec_unit/dec_wr_dest back.
module tb_v_issue_ctrl;

  localparam logic [31:0] ALU_W = 32'h0220_8057;
  localparam logic [31:0] LD_A  = 32'h5800_0001;  // VLOAD, writes dest
  localparam logic [31:0] ALU_B = 32'h1800_0002;
  localparam logic [31:0] ALU_C = 32'h1800_0003;
  localparam logic [31:0] ST_D  = 32'h6000_0004;  // VSTORE, no dest
  localparam logic [31:0] CFG_E = 32'h7000_0010;
  localparam logic [31:0] MUL_F = 32'h2800_0005;
  localparam logic [31:0] ALU_G = 32'h1800_0006;
  localparam logic [31:0] ILL_H = 32'h0000_0007;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  v_issue_ctrl_if bus ();
  v_issue_ctrl_if tbus ();

  v_issue_ctrl #(.QDEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  v_issue_ctrl #(.QDEPTH(2), .TIMEOUT(8)) dut_t (
    .clk (clk),
    .rst (rst),
    .bus (tbus)
  );

  // decoder model: unit class in [30:28], writes-dest in [27], except the sample ALU word
  function automatic logic [2:0] dec_unit_f(logic [31:0] w);
    if (w == ALU_W) return 3'd1;
    return w[30:28];
  endfunction

  function automatic logic dec_wr_f(logic [31:0] w);
    if (w == ALU_W) return 1'b1;
    return w[27];
  endfunction

  assign bus.dec_unit     = dec_unit_f(bus.dec_instr);
  assign bus.dec_wr_dest  = dec_wr_f(bus.dec_instr);
  assign tbus.dec_unit    = dec_unit_f(tbus.dec_instr);
  assign tbus.dec_wr_dest = dec_wr_f(tbus.dec_instr);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.instr_valid  = 1'b0; bus.instr_in  = '0; bus.unit_done  = '0; bus.err_clr  = 1'b0;
    tbus.instr_valid = 1'b0; tbus.instr_in = '0; tbus.unit_done = '0; tbus.err_clr = 1'b0;
    #12;
    check_eq("rst_ready", bus.instr_ready, 1'b1);
    check_eq("rst_dec_instr", bus.dec_instr, 32'h0);
    check_eq("rst_start", bus.unit_start, 6'b0);
    check_eq("rst_vcfg", bus.vconfig_wr_en, 1'b0);
    check_eq("rst_wb", bus.wb_en, 1'b0);
    check_eq("rst_busy", bus.busy, 1'b0);
    check_eq("rst_errs", {bus.err_illegal, bus.err_timeout}, 2'b00);
    rst = 1'b0;
    tick();

    // single ALU instruction, done at cycle 5
    bus.instr_valid = 1'b1; bus.instr_in = ALU_W;
    tick();                                                    // c1
    bus.instr_valid = 1'b0;
    check_eq("alu_start_c1", bus.unit_start, 6'b0);
    check_eq("alu_head", bus.dec_instr, ALU_W);
    check_eq("alu_busy_c1", bus.busy, 1'b1);
    tick();                                                    // c2
    check_eq("alu_start_c2", bus.unit_start, 6'b000001);
    tick();                                                    // c3
    check_eq("alu_start_c3", bus.unit_start, 6'b0);
    tick(2);                                                   // c5
    check_eq("alu_wb_c5", bus.wb_en, 1'b0);
    bus.unit_done = 6'b000001;
    tick();                                                    // c6
    bus.unit_done = '0;
    check_eq("alu_wb_c6", bus.wb_en, 1'b1);
    tick();                                                    // c7
    check_eq("alu_wb_c7", bus.wb_en, 1'b0);
    check_eq("alu_busy_c7", bus.busy, 1'b0);
    check_eq("alu_empty_c7", bus.dec_instr, 32'h0);

    // back-pressure: VLOAD (10 cycles in ISSUE+WAIT), then two ALUs
    bus.instr_valid = 1'b1; bus.instr_in = LD_A;
    check_eq("bp_ready_c0", bus.instr_ready, 1'b1);
    tick();                                                    // c1
    bus.instr_in = ALU_B;
    check_eq("bp_ready_c1", bus.instr_ready, 1'b1);
    tick();                                                    // c2
    bus.instr_in = ALU_C;
    check_eq("bp_ready_c2", bus.instr_ready, 1'b0);
    check_eq("bp_start_ld", bus.unit_start, 6'b010000);
    tick(9);                                                   // c11
    check_eq("bp_ready_c11", bus.instr_ready, 1'b0);
    check_eq("bp_head_c11", bus.dec_instr, LD_A);
    bus.unit_done = 6'b010000;
    tick();                                                    // c12
    bus.unit_done = '0;
    check_eq("bp_wb_ld", bus.wb_en, 1'b1);
    check_eq("bp_ready_c12", bus.instr_ready, 1'b0);
    tick();                                                    // c13
    check_eq("bp_ready_c13", bus.instr_ready, 1'b1);
    check_eq("bp_head_b", bus.dec_instr, ALU_B);
    tick();                                                    // c14
    bus.instr_valid = 1'b0;
    check_eq("bp_start_b", bus.unit_start, 6'b000001);
    check_eq("bp_head_b_c14", bus.dec_instr, ALU_B);
    bus.unit_done = 6'b000001;
    tick();                                                    // c15
    bus.unit_done = '0;
    check_eq("bp_wb_b", bus.wb_en, 1'b1);
    tick();                                                    // c16
    check_eq("bp_head_c", bus.dec_instr, ALU_C);
    tick();                                                    // c17
    check_eq("bp_start_c", bus.unit_start, 6'b000001);
    bus.unit_done = 6'b000001;
    tick();                                                    // c18
    bus.unit_done = '0;
    check_eq("bp_wb_c", bus.wb_en, 1'b1);
    tick();                                                    // c19
    check_eq("bp_busy_end", bus.busy, 1'b0);

    // VSTORE with done in the start cycle
    bus.instr_valid = 1'b1; bus.instr_in = ST_D;
    tick();                                                    // c1
    bus.instr_valid = 1'b0;
    tick();                                                    // c2
    check_eq("st_start", bus.unit_start, 6'b100000);
    bus.unit_done = 6'b100000;
    tick();                                                    // c3
    bus.unit_done = '0;
    check_eq("st_wb", bus.wb_en, 1'b0);
    check_eq("st_busy_c3", bus.busy, 1'b1);
    check_eq("st_start_c3", bus.unit_start, 6'b0);
    tick();                                                    // c4
    check_eq("st_busy_c4", bus.busy, 1'b0);
    check_eq("st_popped", bus.dec_instr, 32'h0);

    // four back-to-back VCONFIGs
    for (int i = 0; i < 6; i++) begin
      bus.instr_valid = (i < 4);
      bus.instr_in    = CFG_E + 32'(i);
      #1;
      check_eq($sformatf("cfg_vcfg_%0d", i), bus.vconfig_wr_en, (i >= 1 && i <= 4));
      check_eq($sformatf("cfg_start_%0d", i), bus.unit_start, 6'b0);
      check_eq($sformatf("cfg_ready_%0d", i), bus.instr_ready, 1'b1);
      if (i >= 1 && i <= 4)
        check_eq($sformatf("cfg_head_%0d", i), bus.dec_instr, CFG_E + 32'(i - 1));
      tick();
    end
    bus.instr_valid = 1'b0;

    // timeout (TIMEOUT=8): VMUL never completes, ALU behind it then issues
    tbus.instr_valid = 1'b1; tbus.instr_in = MUL_F;
    tick();                                                    // c1
    tbus.instr_in = ALU_G;
    tick();                                                    // c2
    tbus.instr_valid = 1'b0;
    check_eq("to_start_mul", tbus.unit_start, 6'b000010);
    for (int c = 2; c < 10; c++) begin
      check_eq($sformatf("to_err_c%0d", c), tbus.err_timeout, 1'b0);
      check_eq($sformatf("to_wb_c%0d", c), tbus.wb_en, 1'b0);
      tbus.unit_done = (c == 5) ? 6'b000001 : 6'b0;            // other unit's done is ignored
      tick();
    end
    tbus.unit_done = '0;                                       // c10
    check_eq("to_err_c10", tbus.err_timeout, 1'b1);
    check_eq("to_wb_c10", tbus.wb_en, 1'b0);
    check_eq("to_head_g", tbus.dec_instr, ALU_G);
    tick();                                                    // c11
    check_eq("to_start_g", tbus.unit_start, 6'b000001);
    tbus.unit_done = 6'b000001;
    tick();                                                    // c12
    tbus.unit_done = '0;
    check_eq("to_wb_g", tbus.wb_en, 1'b1);
    tick();                                                    // c13
    tbus.err_clr = 1'b1;
    check_eq("to_err_held", tbus.err_timeout, 1'b1);
    tick();                                                    // c14
    tbus.err_clr = 1'b0;
    check_eq("to_err_clr", tbus.err_timeout, 1'b0);

    // illegal instruction, then set-wins-over-clear
    bus.instr_valid = 1'b1; bus.instr_in = ILL_H;
    tick();                                                    // c1
    bus.instr_valid = 1'b0;
    check_eq("ill_err_c1", bus.err_illegal, 1'b0);
    check_eq("ill_start_c1", bus.unit_start, 6'b0);
    tick();                                                    // c2
    check_eq("ill_err_c2", bus.err_illegal, 1'b1);
    check_eq("ill_popped", bus.dec_instr, 32'h0);
    check_eq("ill_busy", bus.busy, 1'b0);
    bus.instr_valid = 1'b1; bus.instr_in = ILL_H;
    tick();                                                    // c3
    bus.instr_valid = 1'b0;
    bus.err_clr = 1'b1;
    tick();                                                    // c4
    bus.err_clr = 1'b0;
    check_eq("ill_set_wins", bus.err_illegal, 1'b1);

    // reset during WAIT
    bus.instr_valid = 1'b1; bus.instr_in = ALU_W;
    tick();
    bus.instr_valid = 1'b0;
    tick(3);                                                   // in WAIT
    check_eq("rw_busy_pre", bus.busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    check_eq("rw_start", bus.unit_start, 6'b0);
    check_eq("rw_wb", bus.wb_en, 1'b0);
    check_eq("rw_busy", bus.busy, 1'b0);
    check_eq("rw_dec_instr", bus.dec_instr, 32'h0);
    check_eq("rw_ready", bus.instr_ready, 1'b1);
    check_eq("rw_err_ill", bus.err_illegal, 1'b0);
    check_eq("rw_vcfg", bus.vconfig_wr_en, 1'b0);
    rst = 1'b0;
    tick();
    bus.unit_done = 6'b000001;
    tick();
    bus.unit_done = '0;
    check_eq("rw_late_wb", bus.wb_en, 1'b0);
    check_eq("rw_late_start", bus.unit_start, 6'b0);
    tick();
    check_eq("rw_late_wb2", bus.wb_en, 1'b0);
    check_eq("rw_late_busy", bus.busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
